// File: rtl/sipo_pkg.sv
// Shared constants and the default-sized output queue entry for the SIPO packer.
package sipo_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_IN_LANES    = 1;
    localparam int DEF_OUT_ENTRIES = 2;
    localparam int DEF_CNT_WIDTH   = $clog2(DEF_DEPTH + 1);

    typedef struct packed {
        logic                                 last;
        logic [DEF_CNT_WIDTH-1:0]             count;
        logic [DEF_DEPTH*DEF_DATA_WIDTH-1:0]  data;
    } entry_t;

    localparam int ENTRY_WIDTH = $bits(entry_t);

endpackage

// File: rtl/sipo_out_queue.sv
// Circular FIFO of packed-word entries; the head reads zero while empty.
module sipo_out_queue
    import sipo_pkg::*;
#(
    parameter int WIDTH   = ENTRY_WIDTH,
    parameter int ENTRIES = DEF_OUT_ENTRIES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int OCC_W = $clog2(ENTRIES + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ENTRIES - 1);
    localparam logic [OCC_W-1:0] MAX_OCC  = OCC_W'(ENTRIES);

    logic [WIDTH-1:0] mem_r [ENTRIES];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers wrap modulo ENTRIES, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    assign full      = (occ_r == MAX_OCC);
    assign empty     = (occ_r == {OCC_W{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
        end else if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

endmodule

// File: rtl/sipo_packer.sv
// Serial-in parallel-out packer: gathers IN_LANES elements per write into DEPTH-element
// words, supports flushing a zero-padded partial word, and queues finished words.
module sipo_packer
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int IN_LANES    = DEF_IN_LANES,
    parameter int OUT_ENTRIES = DEF_OUT_ENTRIES,
    parameter int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_clear,
    input  logic                           i_wen,
    input  logic [IN_LANES*DATA_WIDTH-1:0] i_data_in,
    output logic                           o_ready,
    input  logic                           i_flush,
    input  logic                           i_ren,
    output logic                           o_valid,
    output logic [DEPTH*DATA_WIDTH-1:0]    o_data_out,
    output logic [CNT_WIDTH-1:0]           o_count,
    output logic                           o_last,
    output logic                           o_empty,
    output logic                           o_full
);

    localparam int WORD_W = DEPTH * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] LANES_C   = CNT_WIDTH'(IN_LANES);
    localparam logic [CNT_WIDTH-1:0] LAST_FILL = CNT_WIDTH'(DEPTH - IN_LANES);

    typedef struct packed {
        logic                 last;
        logic [CNT_WIDTH-1:0] count;
        logic [WORD_W-1:0]    data;
    } word_entry_t;

    logic [CNT_WIDTH-1:0] fill_r;
    logic [WORD_W-1:0]    pack_r;
    logic                 flush_pending_r;

    logic                 ready_s;
    logic                 wr_acc_s;
    logic                 pend_s;
    logic [WORD_W-1:0]    pack_w_s;
    logic [CNT_WIDTH-1:0] fill_w_s;
    logic [WORD_W-1:0]    pack_next_s;
    logic [CNT_WIDTH-1:0] fill_next_s;
    logic                 pend_next_s;
    logic                 push_s;
    word_entry_t          push_entry_s;
    word_entry_t          head_s;
    logic                 q_full_s;
    logic                 q_empty_s;

    // Slots at or above the fill level may hold stale elements of an earlier word.
    function automatic logic [WORD_W-1:0] zero_from_fill(input logic [WORD_W-1:0] word,
                                                         input logic [CNT_WIDTH-1:0] fill);
        logic [WORD_W-1:0] res;
        res = word;
        for (int s = 0; s < DEPTH; s++) begin
            if (s >= int'(fill)) begin
                res[s*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end else begin
                res[s*DATA_WIDTH +: DATA_WIDTH] = word[s*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return res;
    endfunction

    assign ready_s  = !flush_pending_r && !(q_full_s && (fill_r == LAST_FILL));
    assign wr_acc_s = i_wen && ready_s;
    assign pend_s   = flush_pending_r || i_flush;

    // Apply the accepted write to a working copy of the packing register.
    always_comb begin
        pack_w_s = pack_r;
        fill_w_s = fill_r;
        if (wr_acc_s) begin
            for (int k = 0; k < IN_LANES; k++) begin
                pack_w_s[(int'(fill_r) + k) * DATA_WIDTH +: DATA_WIDTH] =
                    i_data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
            fill_w_s = fill_r + LANES_C;
        end else begin
            fill_w_s = fill_r;
        end
    end

    // Decide word completion, flush emission and the next packing state.
    always_comb begin
        pack_next_s  = pack_w_s;
        fill_next_s  = fill_w_s;
        pend_next_s  = pend_s;
        push_s       = 1'b0;
        push_entry_s = '0;
        if (fill_w_s == DEPTH_C) begin
            // A full word absorbs a coincident flush and carries its last marker.
            push_s             = 1'b1;
            push_entry_s.data  = pack_w_s;
            push_entry_s.count = DEPTH_C;
            push_entry_s.last  = pend_s;
            fill_next_s        = {CNT_WIDTH{1'b0}};
            pend_next_s        = 1'b0;
        end else if (pend_s) begin
            if (fill_w_s == {CNT_WIDTH{1'b0}}) begin
                pend_next_s = 1'b0;
            end else if (!q_full_s) begin
                push_s             = 1'b1;
                push_entry_s.data  = zero_from_fill(pack_w_s, fill_w_s);
                push_entry_s.count = fill_w_s;
                push_entry_s.last  = 1'b1;
                fill_next_s        = {CNT_WIDTH{1'b0}};
                pend_next_s        = 1'b0;
            end else begin
                pend_next_s = 1'b1;
            end
        end else begin
            pend_next_s = 1'b0;
        end
    end

    // Packing register, fill level and sticky flush request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fill_r          <= {CNT_WIDTH{1'b0}};
            pack_r          <= {WORD_W{1'b0}};
            flush_pending_r <= 1'b0;
        end else if (i_clear) begin
            fill_r          <= {CNT_WIDTH{1'b0}};
            pack_r          <= {WORD_W{1'b0}};
            flush_pending_r <= 1'b0;
        end else begin
            fill_r          <= fill_next_s;
            pack_r          <= pack_next_s;
            flush_pending_r <= pend_next_s;
        end
    end

    sipo_out_queue #(
        .WIDTH   ($bits(word_entry_t)),
        .ENTRIES (OUT_ENTRIES)
    ) u_out_queue (
        .clk       (i_clk),
        .rst       (i_rst),
        .clear     (i_clear),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (i_ren),
        .head      (head_s),
        .full      (q_full_s),
        .empty     (q_empty_s)
    );

    assign o_ready    = ready_s;
    assign o_valid    = !q_empty_s;
    assign o_data_out = head_s.data;
    assign o_count    = head_s.count;
    assign o_last     = head_s.last;
    assign o_full     = q_full_s;
    assign o_empty    = q_empty_s && (fill_r == {CNT_WIDTH{1'b0}}) && !flush_pending_r;

endmodule

// File: tb/tb_sipo_packer.sv
// Bench for sipo_packer: one-lane and two-lane instances against a queue-based model.
module tb_sipo_packer;
    import sipo_pkg::*;

    logic        clk = 1'b0;
    logic        rst, clr, wen, flush, ren;
    logic [15:0] din;

    logic        rdy [2];
    logic        vld [2];
    logic        lst [2];
    logic        emp [2];
    logic        ful [2];
    logic [63:0] dout [2];
    logic [3:0]  cnt [2];

    always #5 clk = ~clk;

    sipo_packer #(.DATA_WIDTH(8), .DEPTH(8), .IN_LANES(1), .OUT_ENTRIES(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_wen(wen), .i_data_in(din[7:0]),
        .o_ready(rdy[0]), .i_flush(flush), .i_ren(ren), .o_valid(vld[0]),
        .o_data_out(dout[0]), .o_count(cnt[0]), .o_last(lst[0]), .o_empty(emp[0]), .o_full(ful[0]));

    sipo_packer #(.DATA_WIDTH(8), .DEPTH(8), .IN_LANES(2), .OUT_ENTRIES(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_wen(wen), .i_data_in(din),
        .o_ready(rdy[1]), .i_flush(flush), .i_ren(ren), .o_valid(vld[1]),
        .o_data_out(dout[1]), .o_count(cnt[1]), .o_last(lst[1]), .o_empty(emp[1]), .o_full(ful[1]));

    // Model: per instance, the elements of the word being gathered and the queued words.
    entry_t mq [2][$];
    int     mcur [2][$];
    bit     mpend [2];
    entry_t cmp_head;
    int     n_checks = 0;
    int     n_errors = 0;
    int     ren_pct = 50;

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, id, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready(int id);
        return !mpend[id] && !(mq[id].size() == 2 && mcur[id].size() == 8 - (id + 1));
    endfunction

    function automatic entry_t build(int id, int n, bit last);
        entry_t e;
        e = '0;
        for (int i = 0; i < n; i++) e.data[8*i +: 8] = 8'(mcur[id][i]);
        e.count = 4'(n);
        e.last  = last;
        return e;
    endfunction

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            mq[id].delete();
            mcur[id].delete();
            mpend[id] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int id = 0; id < 2; id++) begin
            bit full, rd, p;
            if (clr) begin
                mq[id].delete();
                mcur[id].delete();
                mpend[id] = 1'b0;
            end else begin
                full = (mq[id].size() == 2);
                rd   = exp_ready(id);
                p    = mpend[id] || flush;
                if (ren && mq[id].size() != 0) void'(mq[id].pop_front());
                if (wen && rd) begin
                    for (int k = 0; k <= id; k++) mcur[id].push_back(int'(din[8*k +: 8]));
                end
                if (mcur[id].size() == 8) begin
                    mq[id].push_back(build(id, 8, p));
                    mcur[id].delete();
                    mpend[id] = 1'b0;
                end else if (p) begin
                    if (mcur[id].size() == 0) begin
                        mpend[id] = 1'b0;
                    end else if (!full) begin
                        mq[id].push_back(build(id, mcur[id].size(), 1'b1));
                        mcur[id].delete();
                        mpend[id] = 1'b0;
                    end else begin
                        mpend[id] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit w, input logic [15:0] d, input bit f, input bit r);
        wen = w; din = d; flush = f; ren = r;
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        clr = 1'b0;
    endtask

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        for (int id = 0; id < 2; id++) begin
            cmp_head = (mq[id].size() != 0) ? mq[id][0] : '0;
            chk("valid", id, 64'(vld[id]), 64'(mq[id].size() != 0));
            chk("data",  id, dout[id], cmp_head.data);
            chk("count", id, 64'(cnt[id]), 64'(cmp_head.count));
            chk("last",  id, 64'(lst[id]), 64'(cmp_head.last));
            chk("empty", id, 64'(emp[id]), 64'(mq[id].size() == 0 && mcur[id].size() == 0 && !mpend[id]));
            chk("full",  id, 64'(ful[id]), 64'(mq[id].size() == 2));
            chk("ready", id, 64'(rdy[id]), 64'(exp_ready(id)));
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; wen = 1'b0; flush = 1'b0; ren = 1'b0; din = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst valid", 0, 64'(vld[0]), 64'd0);
        chk("rst empty", 0, 64'(emp[0]), 64'd1);
        chk("rst ready", 0, 64'(rdy[0]), 64'd1);
        rst = 1'b0;

        // Full word, consumer always ready.
        for (int i = 0; i < 8; i++) step(1'b1, {8'(i + 8'h40), 8'(i)}, 1'b0, 1'b1);
        chk("t1 valid", 0, 64'(vld[0]), 64'd1);
        chk("t1 data",  0, dout[0], 64'h0706050403020100);
        chk("t1 count", 0, 64'(cnt[0]), 64'd8);
        chk("t1 last",  0, 64'(lst[0]), 64'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("t1 popped", 0, 64'(vld[0]), 64'd0);

        // Partial word by flush.
        step(1'b1, 16'h0011, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 1'b0, 1'b0);
        step(1'b1, 16'h0033, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("t2 data",  0, dout[0], 64'h0000000000332211);
        chk("t2 count", 0, 64'(cnt[0]), 64'd3);
        chk("t2 last",  0, 64'(lst[0]), 64'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("t2 empty", 0, 64'(emp[0]), 64'd1);

        // Backpressure with a full queue.
        do_clear();
        for (int i = 0; i < 23; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("t3 ready low", 0, 64'(rdy[0]), 64'd0);
        chk("t3 full", 0, 64'(ful[0]), 64'd1);
        step(1'b1, 16'd23, 1'b0, 1'b1);
        chk("t3 ready back", 0, 64'(rdy[0]), 64'd1);
        chk("t3 head1", 0, dout[0], 64'h0f0e0d0c0b0a0908);
        step(1'b1, 16'd23, 1'b0, 1'b0);
        chk("t3 refull", 0, 64'(ful[0]), 64'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("t3 head2", 0, dout[0], 64'h1716151413121110);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("t3 drained", 0, 64'(vld[0]), 64'd0);

        // Two lanes per write.
        do_clear();
        step(1'b1, 16'h0100, 1'b0, 1'b0);
        step(1'b1, 16'h0302, 1'b0, 1'b0);
        step(1'b1, 16'h0504, 1'b0, 1'b0);
        step(1'b1, 16'h0706, 1'b0, 1'b0);
        chk("t4 valid", 1, 64'(vld[1]), 64'd1);
        chk("t4 data",  1, dout[1], 64'h0706050403020100);
        chk("t4 count", 1, 64'(cnt[1]), 64'd8);

        // Flush waits for room in a full queue.
        do_clear();
        for (int i = 0; i < 18; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("t5 pend ready", 0, 64'(rdy[0]), 64'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("t5 still pend", 0, 64'(rdy[0]), 64'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("t5 flushed ready", 0, 64'(rdy[0]), 64'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("t5 data",  0, dout[0], 64'h0000000000001110);
        chk("t5 count", 0, 64'(cnt[0]), 64'd2);
        chk("t5 last",  0, 64'(lst[0]), 64'd1);

        // Asynchronous reset mid-word.
        do_clear();
        for (int i = 0; i < 13; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("t6 valid", 0, 64'(vld[0]), 64'd0);
        chk("t6 data",  0, dout[0], 64'd0);
        chk("t6 count", 0, 64'(cnt[0]), 64'd0);
        chk("t6 last",  0, 64'(lst[0]), 64'd0);
        chk("t6 empty", 0, 64'(emp[0]), 64'd1);
        chk("t6 full",  0, 64'(ful[0]), 64'd0);
        chk("t6 ready", 0, 64'(rdy[0]), 64'd1);
        rst = 1'b0;
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("t6 noop flush", 0, 64'(vld[0]), 64'd0);
        chk("t6 noop empty", 0, 64'(emp[0]), 64'd1);

        // Randomized traffic with varying consumer readiness.
        for (int n = 0; n < 4000; n++) begin
            if (n % 256 == 0) ren_pct = int'($urandom_range(10, 95));
            if ($urandom_range(0, 199) == 0) begin
                do_clear();
            end else if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                model_reset();
                #1 rst = 1'b0;
            end else begin
                step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 15) == 0,
                     int'($urandom_range(0, 99)) < ren_pct);
            end
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
